// File: rtl/decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pkg : shared defaults, index type and one-hot helper for the decoder
// Revision    : 1.0
// ---------------------------------------------------------------------------
package decoder_pkg;

  localparam int DEC_SEL_W = 5;
  localparam int DEC_LO_W  = 2;

  // Widest index the shared helper can decode; callers slice the low bits.
  localparam int DEC_IDX_MAX_W    = 8;
  localparam int DEC_ONEHOT_MAX_W = 2 ** DEC_IDX_MAX_W;

  typedef logic [DEC_SEL_W-1:0] dec_sel_t;

  function automatic logic [DEC_ONEHOT_MAX_W-1:0] onehot_f(
    input logic [DEC_IDX_MAX_W-1:0] idx,
    input logic                     en
  );
    logic [DEC_ONEHOT_MAX_W-1:0] vec;
    vec = '0;
    if (en) vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_pipe_onehot_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_stage : enabled N to 2**N combinational one-hot decoder
// Revision      : 1.0
// ---------------------------------------------------------------------------
module decoder_stage
  import decoder_pkg::*;
#(
  parameter int N = 2
) (
  input  logic           en_i,
  input  logic [N-1:0]   sel_i,
  output logic [2**N-1:0] out_o
);

  localparam int OUT_W = 2 ** N;

  logic [DEC_ONEHOT_MAX_W-1:0] w_full;

  assign w_full = onehot_f(DEC_IDX_MAX_W'(sel_i), en_i);
  assign out_o  = w_full[OUT_W-1:0];

  if (OUT_W < DEC_ONEHOT_MAX_W) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^w_full[DEC_ONEHOT_MAX_W-1:OUT_W];
  end

endmodule
`default_nettype wire

// File: rtl/decoder_pipe_onehot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pipe_onehot : two-stage valid/ready one-hot decoder (HI field, then LO)
// Option DEC_ZERO_REG_MASK_EN : all-ones index decodes to zero.  Revision 1.0
// ---------------------------------------------------------------------------
module decoder_pipe_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = DEC_SEL_W,
  parameter int LO_W  = DEC_LO_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               en_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2**SEL_W-1:0] out_o
);

  localparam int OUT_W  = 2 ** SEL_W;
  localparam int HI_W   = SEL_W - LO_W;
  localparam int GRP_W  = 2 ** HI_W;
  localparam int GRP_SZ = 2 ** LO_W;

  if (LO_W < 1 || LO_W >= SEL_W || HI_W > DEC_IDX_MAX_W) begin : g_bad_param
    $error("decoder_pipe_onehot: illegal SEL_W/LO_W combination");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [GRP_W-1:0]  s1_grp_q,   s1_grp_d;
  logic [LO_W-1:0]   s1_lo_q,    s1_lo_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_q,      out_d;

  logic              w_dec_en;
  logic [GRP_W-1:0]  w_grp;
  logic [OUT_W-1:0]  w_out;
  logic              w_s2_ready;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_advance;

`ifdef DEC_ZERO_REG_MASK_EN
  // The all-ones index is the hard-wired zero register: never enable it.
  assign w_dec_en = en_i && !(&sel_i);
`else
  assign w_dec_en = en_i;
`endif

  decoder_stage #(.N(HI_W)) u_hi_dec (
    .en_i  (w_dec_en),
    .sel_i (sel_i[SEL_W-1:LO_W]),
    .out_o (w_grp)
  );

  for (genvar g = 0; g < GRP_W; g++) begin : g_lo_dec
    decoder_stage #(.N(LO_W)) u_lo_dec (
      .en_i  (s1_grp_q[g]),
      .sel_i (s1_lo_q),
      .out_o (w_out[g*GRP_SZ +: GRP_SZ])
    );
  end

  assign w_s2_ready = !out_valid_q || out_ready_i;
  assign w_in_ready = !s1_valid_q || w_s2_ready;
  assign w_accept   = in_valid_i && w_in_ready;
  assign w_advance  = s1_valid_q && w_s2_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_grp_d    = s1_grp_q;
    s1_lo_d     = s1_lo_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      s1_grp_d    = '0;
      out_valid_d = 1'b0;
      out_d       = '0;
    end else begin
      if (w_advance) begin
        out_valid_d = 1'b1;
        out_d       = w_out;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
        out_d       = '0;
      end
      if (w_accept) begin
        s1_valid_d = 1'b1;
        s1_grp_d   = w_grp;
        s1_lo_d    = sel_i[LO_W-1:0];
      end else if (w_advance) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_grp_q    <= '0;
      s1_lo_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_grp_q    <= s1_grp_d;
      s1_lo_q     <= s1_lo_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe_onehot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decoder_pipe_onehot : vector table, corner sequences and random traffic
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_decoder_pipe_onehot;

  parameter int SEL_W = 5;
  parameter int LO_W  = 2;
  localparam int OUT_W = 2 ** SEL_W;

  logic             clk = 1'b0;
  logic             reset_i, flush_i, in_valid_i, en_i, out_ready_i;
  logic [SEL_W-1:0] sel_i;
  logic             in_ready_o, out_valid_o;
  logic [OUT_W-1:0] out_o;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_pipe_onehot #(.SEL_W(SEL_W), .LO_W(LO_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .en_i        (en_i),
    .sel_i       (sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t tab [OUT_W+1];

  // Transaction-level model: FIFO of expected words, head visible when m_full.
  logic [OUT_W-1:0] m_q [$];
  bit               m_full;

  function automatic logic [OUT_W-1:0] exp_word(input logic en, input int sel);
    logic [OUT_W-1:0] one;
    one = 1;
    if (!en) return '0;
`ifdef DEC_ZERO_REG_MASK_EN
    if (sel == OUT_W - 1) return '0;
`endif
    return one << sel;
  endfunction

  task automatic cmp(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_in_ready();
    return (m_q.size() < 2) || out_ready_i;
  endfunction

  task automatic model_check();
    cmp("in_ready", OUT_W'(in_ready_o), OUT_W'(m_in_ready()));
    cmp("out_valid", OUT_W'(out_valid_o), OUT_W'(m_full));
    cmp("out_word", out_o, m_full ? m_q[0] : '0);
    cmp("onehot", OUT_W'($countones(out_o) <= 1), OUT_W'(1));
  endtask

  task automatic model_update();
    logic rdy, pop, adv;
    if (reset_i || flush_i) begin
      m_q.delete();
      m_full = 1'b0;
    end else begin
      rdy = m_in_ready();
      pop = m_full && out_ready_i;
      adv = (m_q.size() > int'(m_full)) && (!m_full || out_ready_i);
      if (pop) void'(m_q.pop_front());
      m_full = adv ? 1'b1 : (pop ? 1'b0 : m_full);
      if (in_valid_i && rdy) m_q.push_back(exp_word(en_i, int'(sel_i)));
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half_check();
    edge_step();
  endtask

  initial begin
    for (int k = 0; k < OUT_W; k++) tab[k] = '{1'b1, SEL_W'(k), exp_word(1'b1, k)};
    tab[OUT_W] = '{1'b0, SEL_W'(7), '0};

    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; en_i = 1'b0;
    out_ready_i = 1'b1; sel_i = '0;
    m_full = 1'b0;
    edge_step();
    edge_step();
    reset_i = 1'b0;

    half_check();
    cmp("rst_out_valid", OUT_W'(out_valid_o), '0);
    cmp("rst_out", out_o, '0);
    cmp("rst_in_ready", OUT_W'(in_ready_o), OUT_W'(1));
    edge_step();

    // Full-rate stream of every index, then an en=0 request.
    for (int j = 0; j < OUT_W + 3; j++) begin
      in_valid_i = (j <= OUT_W);
      if (j <= OUT_W) begin
        en_i  = tab[j].en;
        sel_i = tab[j].sel;
      end
      half_check();
      cmp("stream_in_ready", OUT_W'(in_ready_o), OUT_W'(1));
      cmp("stream_valid", OUT_W'(out_valid_o), OUT_W'(j >= 2));
      if (j >= 2) cmp("stream_out", out_o, tab[j-2].exp);
      edge_step();
    end
    in_valid_i = 1'b0;
    cycle();
    cycle();

    // Back-pressure with both stages full.
    out_ready_i = 1'b0; en_i = 1'b1; in_valid_i = 1'b1;
    sel_i = SEL_W'(3); cycle();
    sel_i = SEL_W'(9); cycle();
    sel_i = SEL_W'(5);
    for (int j = 0; j < 3; j++) begin
      half_check();
      cmp("stall_out", out_o, OUT_W'(32'h8));
      cmp("stall_valid", OUT_W'(out_valid_o), OUT_W'(1));
      cmp("stall_in_ready", OUT_W'(in_ready_o), '0);
      edge_step();
    end
    out_ready_i = 1'b1; in_valid_i = 1'b0;
    cycle();
    half_check();
    cmp("release_out", out_o, OUT_W'(32'h200));
    edge_step();
    half_check();
    cmp("drain_valid", OUT_W'(out_valid_o), '0);
    cmp("drain_out", out_o, '0);
    edge_step();

    // Flush with both stages full and a concurrent accept.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    sel_i = SEL_W'(1); cycle();
    sel_i = SEL_W'(2); cycle();
    out_ready_i = 1'b1; flush_i = 1'b1; sel_i = SEL_W'(6);
    cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      half_check();
      cmp("flush_valid", OUT_W'(out_valid_o), '0);
      cmp("flush_out", out_o, '0);
      edge_step();
    end

    // Reset mid-stream, together with flush and an accept.
    in_valid_i = 1'b1;
    sel_i = SEL_W'(4); cycle();
    sel_i = SEL_W'(8); cycle();
    reset_i = 1'b1; flush_i = 1'b1; sel_i = SEL_W'(10);
    edge_step();
    reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    half_check();
    cmp("mid_rst_valid", OUT_W'(out_valid_o), '0);
    cmp("mid_rst_out", out_o, '0);
    cmp("mid_rst_in_ready", OUT_W'(in_ready_o), OUT_W'(1));
    edge_step();
    half_check();
    cmp("mid_rst_nolate", OUT_W'(out_valid_o), '0);
    edge_step();

    // Zero-register index on its own.
    in_valid_i = 1'b1; en_i = 1'b1; sel_i = SEL_W'(OUT_W - 1);
    cycle();
    in_valid_i = 1'b0;
    cycle();
    half_check();
    cmp("top_idx_valid", OUT_W'(out_valid_o), OUT_W'(1));
`ifdef DEC_ZERO_REG_MASK_EN
    cmp("top_idx_out", out_o, '0);
`else
    cmp("top_idx_out", out_o, OUT_W'(1) << (OUT_W - 1));
`endif
    edge_step();

    for (int j = 0; j < 3000; j++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      en_i        = ($urandom_range(0, 7) != 0);
      sel_i       = SEL_W'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      reset_i     = ($urandom_range(0, 127) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
